pc_call_stack: RTL and testbench
================================

Name: pc_call_stack

Overview:
- Next-generation Hack program counter with a parametrised width and an integrated hardware return-address stack for CALL/RET.
- Sits in the CPU fetch path and drives the ROM address.
- Superset of the plain PC: reset / load / inc keep their existing meaning.
- Adds `call` (push return address, jump) and `ret` (pop, jump back), with depth tracking and sticky error flags.

Parameters:
- WIDTH, 16, address width of the PC, of `in`, and of each stack entry.
- DEPTH, 8, number of return-stack entries; must be ≥2.
- TRAP_ADDR, 0, target address used only when PC_ERR_TRAP_EN is defined.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in  input  WIDTH  jump/call target address.
- load  input  1  PC ← in.
- inc  input  1  PC ← out+1.
- call  input  1  push out+1 onto the stack; PC ← in.
- ret  input  1  pop the stack; PC ← popped value.
- err_clr  input  1  synchronous clear of overflow and underflow.
- out  output  WIDTH  current PC.
- top  output  WIDTH  stack-top entry; 0 when empty.
- depth  output  $clog2(DEPTH+1)  number of valid entries.
- full  output  1  depth==DEPTH.
- empty  output  1  depth==0.
- overflow  output  1  sticky: a call was made while full.
- underflow  output  1  sticky: a ret was made while empty.

Behaviour:
- Reset
  - reset_n low asynchronously forces: out=0, depth=0, overflow=0, underflow=0, all stack entries=0.
  - Consequently top=0, empty=1, full=0.
  - Reset asserted mid-operation discards all pending state. The first edge after release evaluates the inputs normally.
- Per rising edge, one action is taken in strict priority: load > call > ret > inc > hold.
  - load: out←in. Stack untouched. Any simultaneous call/ret is ignored (no push, no pop, no flag change).
  - call (not full):
    - stack[depth]←out+1 (mod 2^WIDTH).
    - depth←depth+1.
    - out←in.
  - call while full:
    - No push; depth stays DEPTH and existing entries are preserved.
    - overflow←1.
    - out←in (the jump still happens).
  - ret (not empty): out←stack[depth-1]; depth←depth-1.
  - ret while empty: out←out+1; underflow←1; depth stays 0.
  - inc: out←out+1, wrapping 2^WIDTH-1 → 0.
  - none: hold.
- Latency: single cycle. All outputs are registered or derived combinationally from registers, with no input-to-output combinational path.
- top = stack[depth-1] when depth>0, else 0. It updates in the same cycle as depth.
- Flags
  - overflow and underflow are sticky until reset_n or err_clr.
  - err_clr has the lowest priority against flag setting: an error event in the same cycle as err_clr leaves the flag set.
  - err_clr does not affect out or the stack.
- call with in==out is legal and pushes out+1 as normal.

Optional Feature:
- Macro PC_ERR_TRAP_EN.
- Defined:
  - call-while-full sets out←TRAP_ADDR instead of in.
  - ret-while-empty sets out←TRAP_ADDR instead of out+1.
  - Flags behave identically.
- Undefined: the behaviour is exactly as above, and TRAP_ADDR is unused.

Test Plan (WIDTH=16, DEPTH=4):
- Reset/inc: release reset_n, inc=1 for 3 cycles → out 0,1,2,3; empty=1, depth=0.
- Nested call/ret:
  - at out=5, call in=0x0100 → out=0x0100, top=6, depth=1.
  - call in=0x0200 → top=0x0101, depth=2.
  - ret → out=0x0101, depth=1.
  - ret → out=6, empty=1.
- Overflow:
  - four calls to 0x0010 → full=1.
  - fifth call in=0x0020 → out=0x0020, depth=4, top=0x0011, overflow=1.
  - err_clr → overflow=0.
- Underflow: at out=0x0030, ret with empty=1 → out=0x0031, underflow=1; flag stays 1 after 3 further inc cycles.
- Priority/wrap:
  - load=1, call=1, in=0xFFFF → out=0xFFFF, depth unchanged.
  - inc → out=0x0000.
  - ret+inc with depth=1, top=0x0042 → out=0x0042.
- Async reset: assert reset_n low mid-cycle with depth=3, out=0x1234 → out=0, depth=0, flags=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_call_stack.sv
// Hack program counter with a hardware return-address stack for CALL/RET.
// Optional macro PC_ERR_TRAP_EN redirects call-while-full / ret-while-empty to TRAP_ADDR.
module pc_call_stack #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 8,
    parameter int TRAP_ADDR = 0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [WIDTH-1:0]           in,
    input  logic                       load,
    input  logic                       inc,
    input  logic                       call,
    input  logic                       ret,
    input  logic                       err_clr,
    output logic [WIDTH-1:0]           out,
    output logic [WIDTH-1:0]           top,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int DW = $clog2(DEPTH+1);

    if (DEPTH < 2 || TRAP_ADDR < 0) begin : g_param_check
        $error("pc_call_stack: DEPTH must be >= 2 and TRAP_ADDR non-negative");
    end

    logic [WIDTH-1:0] pc_reg, pc_next;
    logic [DW-1:0]    depth_reg, depth_next;
    logic             overflow_reg, overflow_next;
    logic             underflow_reg, underflow_next;
    logic [WIDTH-1:0] stack_reg [DEPTH];

    logic [WIDTH-1:0] pc_plus1;
    logic [WIDTH-1:0] top_value;
    logic             full_now, empty_now;
    logic             push;
    logic             overflow_set, underflow_set;

    assign pc_plus1  = pc_reg + WIDTH'(1);
    assign full_now  = (depth_reg == DW'(DEPTH));
    assign empty_now = (depth_reg == '0);

    // Top-of-stack mux; indexing by depth-1 directly would need a narrower index.
    always_comb begin
        top_value = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (depth_reg == DW'(i + 1)) top_value = stack_reg[i];
        end
    end

    always_comb begin
        pc_next       = pc_reg;
        depth_next    = depth_reg;
        push          = 1'b0;
        overflow_set  = 1'b0;
        underflow_set = 1'b0;
        if (load) begin
            pc_next = in;
        end else if (call) begin
            if (full_now) begin
                overflow_set = 1'b1;
`ifdef PC_ERR_TRAP_EN
                pc_next = WIDTH'(TRAP_ADDR);
`else
                pc_next = in;
`endif
            end else begin
                push       = 1'b1;
                depth_next = depth_reg + DW'(1);
                pc_next    = in;
            end
        end else if (ret) begin
            if (empty_now) begin
                underflow_set = 1'b1;
`ifdef PC_ERR_TRAP_EN
                pc_next = WIDTH'(TRAP_ADDR);
`else
                pc_next = pc_plus1;
`endif
            end else begin
                depth_next = depth_reg - DW'(1);
                pc_next    = top_value;
            end
        end else if (inc) begin
            pc_next = pc_plus1;
        end
        // An error event in the same cycle as err_clr wins.
        overflow_next  = overflow_set  | (overflow_reg  & ~err_clr);
        underflow_next = underflow_set | (underflow_reg & ~err_clr);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_reg        <= '0;
            depth_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
            for (int i = 0; i < DEPTH; i++) stack_reg[i] <= '0;
        end else begin
            pc_reg        <= pc_next;
            depth_reg     <= depth_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
            for (int i = 0; i < DEPTH; i++) begin
                if (push && depth_reg == DW'(i)) stack_reg[i] <= pc_plus1;
            end
        end
    end

    assign out       = pc_reg;
    assign top       = top_value;
    assign depth     = depth_reg;
    assign full      = full_now;
    assign empty     = empty_now;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;
endmodule

// File: tb/tb_pc_call_stack.sv
// Scoreboard bench for pc_call_stack (WIDTH=16, DEPTH=4): driver queues expected
// output vectors, a monitor pops and compares them on the falling edge.
module tb_pc_call_stack;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] in = '0;
    logic        load = 1'b0, inc = 1'b0, call = 1'b0, ret = 1'b0, err_clr = 1'b0;
    logic [15:0] out, top;
    logic [2:0]  depth;
    logic        full, empty, overflow, underflow;

    pc_call_stack #(.WIDTH(16), .DEPTH(4), .TRAP_ADDR(0)) dut (
        .clk(clk), .reset_n(reset_n), .in(in), .load(load), .inc(inc),
        .call(call), .ret(ret), .err_clr(err_clr), .out(out), .top(top),
        .depth(depth), .full(full), .empty(empty), .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [38:0] vec;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;
    logic mon_kick = 1'b0;

    function automatic logic [38:0] mk(input logic [15:0] o, input logic [15:0] t,
                                       input logic [2:0] d, input logic ov, input logic un);
        return {o, t, d, (d == 3'd4), (d == 3'd0), ov, un};
    endfunction

    // Monitor: one comparison per queued expectation.
    exp_t        m_e;
    logic [38:0] m_act;
    always @(negedge clk or posedge mon_kick) begin
        if (exp_q.size() > 0) begin
            m_e   = exp_q.pop_front();
            m_act = {out, top, depth, full, empty, overflow, underflow};
            checks++;
            if (m_act !== m_e.vec) begin
                fails++;
                $display("FAIL %s: got out=%h top=%h depth=%0d full=%b empty=%b ovf=%b udf=%b, expected out=%h top=%h depth=%0d full=%b empty=%b ovf=%b udf=%b",
                         m_e.name, m_act[38:23], m_act[22:7], m_act[6:4], m_act[3], m_act[2], m_act[1], m_act[0],
                         m_e.vec[38:23], m_e.vec[22:7], m_e.vec[6:4], m_e.vec[3], m_e.vec[2], m_e.vec[1], m_e.vec[0]);
            end else begin
                $display("ok   %s: out=%h top=%h depth=%0d ovf=%b udf=%b",
                         m_e.name, out, top, depth, overflow, underflow);
            end
        end
    end

    task automatic step(input logic ld, input logic cl, input logic rt, input logic ic,
                        input logic ec, input logic [15:0] din, input string nm,
                        input logic [38:0] v);
        exp_t e;
        @(negedge clk);
        load = ld; call = cl; ret = rt; inc = ic; err_clr = ec; in = din;
        @(posedge clk);
        #1;
        e.name = nm;
        e.vec  = v;
        exp_q.push_back(e);
    endtask

    initial begin
        exp_t e;
        e.name = "reset_state";
        e.vec  = mk(16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0);
        exp_q.push_back(e);
        @(negedge clk);
        reset_n = 1'b1;

        //   ld  cl  rt  ic  ec  in
        step(0, 0, 0, 0, 0, 16'h0000, "hold_after_reset", mk(16'h0000, 16'h0000, 3'd0, 0, 0));
        step(0, 0, 0, 1, 0, 16'h0000, "inc_1",  mk(16'h0001, 16'h0000, 3'd0, 0, 0));
        step(0, 0, 0, 1, 0, 16'h0000, "inc_2",  mk(16'h0002, 16'h0000, 3'd0, 0, 0));
        step(0, 0, 0, 1, 0, 16'h0000, "inc_3",  mk(16'h0003, 16'h0000, 3'd0, 0, 0));
        step(0, 0, 0, 1, 0, 16'h0000, "inc_4",  mk(16'h0004, 16'h0000, 3'd0, 0, 0));
        step(0, 0, 0, 1, 0, 16'h0000, "inc_5",  mk(16'h0005, 16'h0000, 3'd0, 0, 0));
        // nested call / ret
        step(0, 1, 0, 0, 0, 16'h0100, "call_0100", mk(16'h0100, 16'h0006, 3'd1, 0, 0));
        step(0, 1, 0, 0, 0, 16'h0200, "call_0200", mk(16'h0200, 16'h0101, 3'd2, 0, 0));
        step(0, 0, 1, 0, 0, 16'h0000, "ret_to_0101", mk(16'h0101, 16'h0006, 3'd1, 0, 0));
        step(0, 0, 1, 0, 0, 16'h0000, "ret_to_0006", mk(16'h0006, 16'h0000, 3'd0, 0, 0));
        // fill to full, then overflow
        step(0, 1, 0, 0, 0, 16'h0010, "fill_1", mk(16'h0010, 16'h0007, 3'd1, 0, 0));
        step(0, 1, 0, 0, 0, 16'h0010, "fill_2", mk(16'h0010, 16'h0011, 3'd2, 0, 0));
        step(0, 1, 0, 0, 0, 16'h0010, "fill_3", mk(16'h0010, 16'h0011, 3'd3, 0, 0));
        step(0, 1, 0, 0, 0, 16'h0010, "fill_4", mk(16'h0010, 16'h0011, 3'd4, 0, 0));
        step(0, 1, 0, 0, 0, 16'h0020, "call_full", mk(16'h0020, 16'h0011, 3'd4, 1, 0));
        step(0, 0, 0, 0, 1, 16'h0000, "err_clr_ovf", mk(16'h0020, 16'h0011, 3'd4, 0, 0));
        step(0, 1, 0, 0, 1, 16'h0021, "call_full_with_clr", mk(16'h0021, 16'h0011, 3'd4, 1, 0));
        step(0, 0, 0, 0, 1, 16'h0000, "err_clr_ovf_2", mk(16'h0021, 16'h0011, 3'd4, 0, 0));
        // drain
        step(0, 0, 1, 0, 0, 16'h0000, "drain_1", mk(16'h0011, 16'h0011, 3'd3, 0, 0));
        step(0, 0, 1, 0, 0, 16'h0000, "drain_2", mk(16'h0011, 16'h0011, 3'd2, 0, 0));
        step(0, 0, 1, 0, 0, 16'h0000, "drain_3", mk(16'h0011, 16'h0007, 3'd1, 0, 0));
        step(0, 0, 1, 0, 0, 16'h0000, "drain_4", mk(16'h0007, 16'h0000, 3'd0, 0, 0));
        // underflow
        step(1, 0, 0, 0, 0, 16'h0030, "load_0030", mk(16'h0030, 16'h0000, 3'd0, 0, 0));
        step(0, 0, 1, 0, 0, 16'h0000, "ret_empty", mk(16'h0031, 16'h0000, 3'd0, 0, 1));
        step(0, 0, 0, 1, 0, 16'h0000, "udf_sticky_1", mk(16'h0032, 16'h0000, 3'd0, 0, 1));
        step(0, 0, 0, 1, 0, 16'h0000, "udf_sticky_2", mk(16'h0033, 16'h0000, 3'd0, 0, 1));
        step(0, 0, 0, 1, 0, 16'h0000, "udf_sticky_3", mk(16'h0034, 16'h0000, 3'd0, 0, 1));
        step(0, 0, 1, 0, 1, 16'h0000, "ret_empty_with_clr", mk(16'h0035, 16'h0000, 3'd0, 0, 1));
        step(0, 0, 0, 0, 1, 16'h0000, "err_clr_udf", mk(16'h0035, 16'h0000, 3'd0, 0, 0));
        // priority and wrap
        step(1, 0, 0, 0, 0, 16'h0041, "load_0041", mk(16'h0041, 16'h0000, 3'd0, 0, 0));
        step(0, 1, 0, 0, 0, 16'h1000, "call_1000", mk(16'h1000, 16'h0042, 3'd1, 0, 0));
        step(1, 1, 0, 0, 0, 16'hFFFF, "load_beats_call", mk(16'hFFFF, 16'h0042, 3'd1, 0, 0));
        step(0, 0, 0, 1, 0, 16'h0000, "inc_wrap", mk(16'h0000, 16'h0042, 3'd1, 0, 0));
        step(0, 0, 1, 1, 0, 16'h0000, "ret_beats_inc", mk(16'h0042, 16'h0000, 3'd0, 0, 0));
        step(1, 0, 1, 0, 0, 16'h0042, "load_beats_ret", mk(16'h0042, 16'h0000, 3'd0, 0, 0));
        step(0, 1, 0, 0, 0, 16'h0042, "call_in_eq_out", mk(16'h0042, 16'h0043, 3'd1, 0, 0));
        step(1, 0, 0, 0, 0, 16'hFFFF, "load_FFFF", mk(16'hFFFF, 16'h0043, 3'd1, 0, 0));
        step(0, 1, 0, 0, 0, 16'h0005, "call_push_wrap", mk(16'h0005, 16'h0000, 3'd2, 0, 0));
        step(0, 1, 0, 0, 0, 16'h1234, "call_1234", mk(16'h1234, 16'h0006, 3'd3, 0, 0));
        // asynchronous reset in the low phase, checked before any clock edge
        @(negedge clk);
        #1;
        load = 0; call = 0; ret = 0; inc = 0; err_clr = 0; in = '0;
        reset_n = 1'b0;
        #1;
        e.name = "async_reset";
        e.vec  = mk(16'h0000, 16'h0000, 3'd0, 0, 0);
        exp_q.push_back(e);
        mon_kick = 1'b1;
        #1;
        mon_kick = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        step(0, 0, 0, 1, 0, 16'h0000, "inc_after_reset", mk(16'h0001, 16'h0000, 3'd0, 0, 0));
        step(0, 1, 0, 0, 0, 16'h0050, "call_after_reset", mk(16'h0050, 16'h0002, 3'd1, 0, 0));
        @(negedge clk);
        load = 0; call = 0; ret = 0; inc = 0; err_clr = 0;

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end
endmodule
